// File: rtl/aoc_pkg.sv
// Shared types and default widths for the puzzle-answer datapath stages.
package aoc_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    DONE
  } acc_state_t;

  localparam int PROD_W_DEF = 32;
  localparam int SUM_W_DEF  = 64;

endpackage

// File: rtl/rise_detect.sv
// Registers a level input and flags the single cycle where it rises.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/mul_accumulator.sv
// Sums the parser's product stream into a saturating total and reports
// the final sum and match count through a valid/ready result port.
module mul_accumulator
  import aoc_pkg::*;
#(
  parameter int PROD_W    = PROD_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              mul_en,
  input  logic              eos,
  input  logic              result_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [CNT_W-1:0]  match_count,
  output logic              result_valid,
  output logic              overflow,
  output logic              busy
);

  localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DCNT_INIT = DCNT_W'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  // Top bit flags a carry out; the value is then pinned at all ones.
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] a,
                                             input logic [SUM_W-1:0] b);
    logic [SUM_W:0] wide;
    wide = {1'b0, a} + {1'b0, b};
    if (wide[SUM_W]) return {1'b1, {SUM_W{1'b1}}};
    return wide;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  acc_state_t        state, state_nxt;
  logic [DCNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic              prod_evt;
  logic              accept;
  logic              handshake;
  logic [SUM_W:0]    add_res;
  logic [SUM_W-1:0]  sum_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              ovf_nxt;

  rise_detect u_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (prod_valid),
    .pulse (prod_evt)
  );

  assign accept    = prod_evt & mul_en & (state != DONE);
  assign handshake = result_valid & result_ready & (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACCUM;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ACCUM: begin
        if (eos) begin
          if (DRAIN_CYC == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DCNT_INIT;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = DONE;
        else                 drain_cnt_nxt = drain_cnt - 1'b1;
      end
      DONE: begin
        if (handshake) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    sum_nxt = sum_out;
    cnt_nxt = match_count;
    ovf_nxt = overflow;
    add_res = sat_add(sum_out, SUM_W'(prod_in));
    if (handshake) begin
      sum_nxt = '0;
      cnt_nxt = '0;
      ovf_nxt = 1'b0;
    end else if (accept) begin
      sum_nxt = add_res[SUM_W-1:0];
      ovf_nxt = overflow | add_res[SUM_W];
      cnt_nxt = sat_inc(match_count);
    end
  end

  // Outputs are registered from next-state values so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_out      <= '0;
      match_count  <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b1;
    end else begin
      sum_out      <= sum_nxt;
      match_count  <= cnt_nxt;
      overflow     <= ovf_nxt;
      result_valid <= (state_nxt == DONE);
      busy         <= (state_nxt != DONE);
    end
  end

endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
- Downstream stage of the `mul(` parser: consumes its product stream (`data_out` / `data_out_valid`) and sums every valid product into a wide running total.
- Optionally gated by a do/don't enable.
- On end-of-stream, drains the parser pipeline, then presents the final sum and match count on a valid/ready result port.
- The result port feeds the answer-reporting logic.

Parameters:
- PROD_W, 32, width of incoming product.
- SUM_W, 64, width of accumulator and sum_out (must be >= PROD_W).
- CNT_W, 16, width of match counter.
- DRAIN_CYC, 2, cycles to keep accepting products after eos.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- prod_in  in  PROD_W  product from parser (`data_out`).
- prod_valid  in  1  parser `data_out_valid`; level signal, may stay high for several cycles.
- mul_en  in  1  1 = products counted, 0 = products discarded (do/don't state).
- eos  in  1  single-cycle end-of-input-stream pulse.
- result_ready  in  1  consumer accepts result.
- sum_out  out  SUM_W  accumulated total.
- match_count  out  CNT_W  number of products accumulated.
- result_valid  out  1  sum_out/match_count final and stable.
- overflow  out  1  sticky; sum saturated.
- busy  out  1  high in ACCUM and DRAIN.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous, active-low, sampled on posedge clk.
  - While low: state=ACCUM, sum_out=0, match_count=0, result_valid=0, overflow=0, busy=1, prev_valid=0.
  - Reset mid-operation (any state, including DONE with result pending) discards everything; no partial result is emitted.
- Product capture:
  - prev_valid registers prod_valid every cycle, in all states.
  - A product event is prod_valid=1 and prev_valid=0 (rising edge). A level held N cycles counts once.
  - An event is accepted only in ACCUM or DRAIN, and only if mul_en=1 in the same cycle.
  - Events in DONE, or with mul_en=0, are ignored; prev_valid still updates.
- Arithmetic on an accepted event (registered, visible the next cycle):
  - sum_out <= sum_out + zero-extended prod_in.
  - If the sum carries out of SUM_W: sum_out <= all ones and overflow <= 1. Once saturated, sum_out stays all ones until reset or handshake.
  - match_count <= match_count + 1, saturating at all ones (no overflow flag for the count).
- State machine:
  - ACCUM:
    - eos=1 -> DRAIN, drain_cnt <= DRAIN_CYC-1.
    - A product event in the same cycle as eos is accepted.
    - If DRAIN_CYC=0, eos goes directly to DONE.
  - DRAIN:
    - Accepts events as in ACCUM.
    - drain_cnt decrements; when drain_cnt==0 -> DONE.
    - eos in DRAIN is ignored.
  - DONE:
    - result_valid=1, busy=0; sum_out and match_count held stable.
    - On result_valid & result_ready: sum_out<=0, match_count<=0, overflow<=0, result_valid<=0 -> ACCUM.
    - eos in DONE is ignored.
    - result_valid never drops without a handshake.
- Latency:
  - eos to result_valid = DRAIN_CYC+1 cycles.
  - An accepted event is reflected in sum_out the next cycle.
- Outputs are registered; no combinational input-to-output path.

Decomposition:
- Shared package aoc_pkg:
  - typedef enum acc_state_t {ACCUM, DRAIN, DONE}.
  - Default width constants PROD_W_DEF=32, SUM_W_DEF=64.
- One natural sub-module: rise_detect (registers a level, outputs the single-cycle rising-edge pulse), reusable by other stages.
- Saturating add stays inline.

Test Plan:
- Sample stream, mul_en=1: products 8, 25, 88, 40, each valid held 1 cycle, then eos; ready=1 -> result_valid after DRAIN_CYC+1 cycles, sum_out=161, match_count=4, overflow=0.
- Same stream with mul_en=0 during the 25 and 88 events -> sum_out=48, match_count=2.
- prod_valid held high 5 cycles with prod_in=7, one event -> sum_out=7, match_count=1. A second rising edge with 3 -> sum_out=10.
- eos in the same cycle as a product event (prod_in=9), followed 1 cycle later by another event (prod_in=1) within DRAIN, with DRAIN_CYC=2 -> sum_out=10, match_count=2.
- SUM_W=32: products 0xFFFF_FFF0 then 0x20 -> sum_out=0xFFFF_FFFF, overflow=1. Handshake -> sum_out=0, overflow=0, state ACCUM.
- DONE with result_ready=0 for 10 cycles, while prod events and eos are applied -> result_valid stays 1, sum_out unchanged. rst_n=0 for 1 cycle -> result_valid=0, sum_out=0, busy=1.
